// File: rtl/sap_pkg.sv
// Shared SAP sequencer definitions: state encoding, opcodes, instruction length.
package sap_pkg;

  localparam int unsigned STATE_W = 4;

  // Sequencer state encoding
  localparam logic [3:0] S_ADDR  = 4'd0;
  localparam logic [3:0] S_INC   = 4'd1;
  localparam logic [3:0] S_MEM   = 4'd2;
  localparam logic [3:0] S_OADDR = 4'd3;
  localparam logic [3:0] S_OINC  = 4'd4;
  localparam logic [3:0] S_OMEM  = 4'd5;
  localparam logic [3:0] S_EXEC  = 4'd6;
  localparam logic [3:0] S_JMP   = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd8;

  // Opcodes
  localparam logic [7:0] OP_LDA   = 8'h3A;
  localparam logic [7:0] OP_STA   = 8'h32;
  localparam logic [7:0] OP_JMP   = 8'hC3;
  localparam logic [7:0] OP_JZ    = 8'hCA;
  localparam logic [7:0] OP_JNZ   = 8'hC2;
  localparam logic [7:0] OP_JM    = 8'hFA;
  localparam logic [7:0] OP_CALL  = 8'hCD;
  localparam logic [7:0] OP_MVI_A = 8'h3E;
  localparam logic [7:0] OP_MVI_B = 8'h06;
  localparam logic [7:0] OP_MVI_C = 8'h0E;
  localparam logic [7:0] OP_ANI   = 8'hE6;
  localparam logic [7:0] OP_ORI   = 8'hF6;
  localparam logic [7:0] OP_XRI   = 8'hEE;
  localparam logic [7:0] OP_IN    = 8'hDB;
  localparam logic [7:0] OP_OUT   = 8'hD3;
  localparam logic [7:0] OP_HLT   = 8'h76;
  localparam logic [7:0] OP_NOP   = 8'h00;

  // Instruction length in bytes: opcodes carrying an operand byte are 2 long
  function automatic logic [1:0] instr_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op)
      OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JNZ, OP_JM, OP_CALL,
      OP_MVI_A, OP_MVI_B, OP_MVI_C, OP_ANI, OP_ORI, OP_XRI,
      OP_IN, OP_OUT: len = 2'd2;
      default:       len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// EXEC watchdog: counts cycles spent in EXEC, flags the last allowed cycle.
module seq_timeout_counter #(
  parameter int unsigned EXEC_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic in_exec,
  output logic expired_c
);

  localparam int unsigned CNT_W = (EXEC_TIMEOUT < 2) ? 1 : $clog2(EXEC_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Cycle counter: held at zero outside EXEC, so every EXEC entry starts fresh
  always_ff @(posedge clk) begin
    if (clr || !in_exec) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds the number of EXEC cycles already completed; a zero limit disables it
  assign expired_c = (EXEC_TIMEOUT != 0) && in_exec &&
                     ((32'(cnt) + 32'd1) == 32'(EXEC_TIMEOUT));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/operand sequencer driving program_counter, MAR and RAM strobes,
// holding IR/operand and handing instructions to the execute controller.
module fetch_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned OPR_W        = 8,
  parameter int unsigned EXEC_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [OPR_W-1:0] bus_in,
  input  logic             exec_done,
  input  logic             jmp_taken,
  output logic             pc_c,
  output logic             pc_l,
  output logic             pc_e,
  output logic             mar_l,
  output logic             ram_e,
  output logic [7:0]       ir_q,
  output logic [OPR_W-1:0] opr_q,
  output logic             exec_start,
  output logic             halted
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               timeout_c;
  logic               pc_c_nxt, pc_l_nxt, pc_e_nxt, mar_l_nxt, ram_e_nxt;
  logic               exec_start_nxt, halted_nxt;

  seq_timeout_counter #(
    .EXEC_TIMEOUT(EXEC_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .clr       (clr),
    .in_exec   (state == S_EXEC),
    .expired_c (timeout_c)
  );

  // Next state plus Moore decode of that state, so outputs come straight from flops
  always_comb begin
    state_nxt      = state;
    pc_c_nxt       = 1'b0;
    pc_l_nxt       = 1'b0;
    pc_e_nxt       = 1'b0;
    mar_l_nxt      = 1'b0;
    ram_e_nxt      = 1'b0;
    exec_start_nxt = 1'b0;
    halted_nxt     = 1'b0;

    case (state)
      S_ADDR:  state_nxt = S_INC;
      S_INC:   state_nxt = S_MEM;
      S_MEM:   state_nxt = (instr_len(8'(bus_in)) == 2'd2) ? S_OADDR : S_EXEC;
      S_OADDR: state_nxt = S_OINC;
      S_OINC:  state_nxt = S_OMEM;
      S_OMEM:  state_nxt = S_EXEC;
      S_EXEC: begin
        if (ir_q == OP_HLT) begin
          state_nxt = S_HALT;
        end else if (exec_done) begin
          state_nxt = jmp_taken ? S_JMP : S_ADDR;
        end else if (timeout_c) begin
          state_nxt = S_ADDR;
        end
      end
      S_JMP:   state_nxt = S_ADDR;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_ADDR;
    endcase

    case (state_nxt)
      S_ADDR, S_OADDR: begin
        pc_e_nxt  = 1'b1;
        mar_l_nxt = 1'b1;
      end
      S_INC, S_OINC: pc_c_nxt  = 1'b1;
      S_MEM, S_OMEM: ram_e_nxt = 1'b1;
      S_EXEC:        exec_start_nxt = (state != S_EXEC);
      S_JMP:         pc_l_nxt  = 1'b1;
      S_HALT:        halted_nxt = 1'b1;
      default:       ;
    endcase
  end

  // State, registered controls and IR/operand capture
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_ADDR;
      pc_c       <= 1'b0;
      pc_l       <= 1'b0;
      pc_e       <= 1'b1;
      mar_l      <= 1'b1;
      ram_e      <= 1'b0;
      exec_start <= 1'b0;
      halted     <= 1'b0;
      ir_q       <= 8'h00;
      opr_q      <= '0;
    end else begin
      state      <= state_nxt;
      pc_c       <= pc_c_nxt;
      pc_l       <= pc_l_nxt;
      pc_e       <= pc_e_nxt;
      mar_l      <= mar_l_nxt;
      ram_e      <= ram_e_nxt;
      exec_start <= exec_start_nxt;
      halted     <= halted_nxt;
      if (state == S_MEM)  ir_q  <= 8'(bus_in);
      if (state == S_OMEM) opr_q <= bus_in;
    end
  end

endmodule
